// File: rtl/gpu_text_writer.sv
// gpu_text_writer
//
// Bus-side writer for the 64x16 text-mode VRAM. Accepts DATA/CURSOR/CTRL/ATTR
// register accesses, keeps a hardware cursor and drives the VRAM write port,
// one 16-bit cell {attr, char} per cycle at address {row[3:0], col[5:0]}.
//
// Ports:
//   clk        single clock
//   W_RST      synchronous active-high reset
//   W_STB      bus strobe, held by the master until W_ACK
//   W_WE       1 = write, 0 = read
//   W_ADDR     register select in W_ADDR[3:2]
//   W_DAT_I    write data
//   W_DAT_O    read data, valid while W_ACK = 1
//   W_ACK      one-cycle completion pulse
//   vram_addr  VRAM write address {row, col}
//   vram_data  VRAM write data {attr, char}
//   vram_we    VRAM write enable

module gpu_text_writer #(
    parameter logic [7:0] CLEAR_CHAR = 8'h20,
    parameter logic [7:0] ATTR_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        W_RST,
    input  logic        W_STB,
    input  logic        W_WE,
    input  logic [31:0] W_ADDR,
    input  logic [31:0] W_DAT_I,
    output logic [31:0] W_DAT_O,
    output logic        W_ACK,
    output logic [9:0]  vram_addr,
    output logic [15:0] vram_data,
    output logic        vram_we
);

    localparam logic [7:0] ChCr = 8'h0D;
    localparam logic [7:0] ChBs = 8'h08;
    localparam logic [7:0] ChLf = 8'h0A;

    localparam logic [1:0] RegData   = 2'd0;
    localparam logic [1:0] RegCursor = 2'd1;
    localparam logic [1:0] RegCtrl   = 2'd2;
    localparam logic [1:0] RegAttr   = 2'd3;

    localparam logic [31:0] CtrlReadValue = 32'h0000_1040;

    typedef enum logic [2:0] {
        StIdle,
        StChar,
        StClrRow,
        StClrAll,
        StAck
    } state_e;

    state_e      state_q;
    logic [5:0]  col_q;
    logic [3:0]  row_q;
    logic [7:0]  attr_q;
    logic [7:0]  last_q;
    logic        ack_q;
    logic [31:0] dat_o_q;
    logic        vram_we_q;
    logic [9:0]  vram_addr_q;
    logic [15:0] vram_data_q;

    logic       accept;
    logic [7:0] wr_char;
    logic [3:0] row_inc;
    logic [1:0] reg_sel;

    assign accept  = (state_q == StIdle) && W_STB && !ack_q;
    assign wr_char = W_DAT_I[7:0];
    assign row_inc = row_q + 4'd1;
    assign reg_sel = W_ADDR[3:2];

    // Address and data bits outside the decoded fields are ignored.
    logic unused_bits;
    assign unused_bits = ^{W_ADDR[31:4], W_ADDR[1:0], W_DAT_I[31:12]};

    always_ff @(posedge clk) begin
        if (W_RST) begin
            state_q     <= StIdle;
            col_q       <= 6'd0;
            row_q       <= 4'd0;
            attr_q      <= ATTR_RESET;
            last_q      <= 8'h00;
            ack_q       <= 1'b0;
            dat_o_q     <= 32'h0;
            vram_we_q   <= 1'b0;
            vram_addr_q <= 10'd0;
            vram_data_q <= 16'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (!W_WE) begin
                            ack_q   <= 1'b1;
                            state_q <= StAck;
                            case (reg_sel)
                                RegData:   dat_o_q <= {16'h0, attr_q, last_q};
                                RegCursor: dat_o_q <= {20'h0, row_q, 2'b00, col_q};
                                RegCtrl:   dat_o_q <= CtrlReadValue;
                                default:   dat_o_q <= {24'h0, attr_q};
                            endcase
                        end else begin
                            dat_o_q <= 32'h0;
                            case (reg_sel)
                                RegData: begin
                                    case (wr_char)
                                        ChCr: begin
                                            col_q   <= 6'd0;
                                            ack_q   <= 1'b1;
                                            state_q <= StAck;
                                        end
                                        ChBs: begin
                                            if (col_q != 6'd0) begin
                                                col_q <= col_q - 6'd1;
                                            end
                                            ack_q   <= 1'b1;
                                            state_q <= StAck;
                                        end
                                        ChLf: begin
                                            // First clear cell goes out with the cursor move.
                                            col_q       <= 6'd0;
                                            row_q       <= row_inc;
                                            vram_we_q   <= 1'b1;
                                            vram_addr_q <= {row_inc, 6'd0};
                                            vram_data_q <= {attr_q, CLEAR_CHAR};
                                            state_q     <= StClrRow;
                                        end
                                        default: begin
                                            vram_we_q   <= 1'b1;
                                            vram_addr_q <= {row_q, col_q};
                                            vram_data_q <= {attr_q, wr_char};
                                            last_q      <= wr_char;
                                            col_q       <= col_q + 6'd1;
                                            if (col_q == 6'd63) begin
                                                row_q <= row_inc;
                                            end
                                            state_q     <= StChar;
                                        end
                                    endcase
                                end
                                RegCursor: begin
                                    col_q   <= W_DAT_I[5:0];
                                    row_q   <= W_DAT_I[11:8];
                                    ack_q   <= 1'b1;
                                    state_q <= StAck;
                                end
                                RegCtrl: begin
                                    if (W_DAT_I[0]) begin
                                        vram_we_q   <= 1'b1;
                                        vram_addr_q <= 10'd0;
                                        vram_data_q <= {attr_q, CLEAR_CHAR};
                                        state_q     <= StClrAll;
                                    end else begin
                                        ack_q   <= 1'b1;
                                        state_q <= StAck;
                                    end
                                end
                                default: begin
                                    attr_q  <= W_DAT_I[7:0];
                                    ack_q   <= 1'b1;
                                    state_q <= StAck;
                                end
                            endcase
                        end
                    end
                end

                StChar: begin
                    // The cursor already advanced; col 0 here means the write wrapped.
                    if (col_q == 6'd0) begin
                        vram_addr_q <= {row_q, 6'd0};
                        vram_data_q <= {attr_q, CLEAR_CHAR};
                        state_q     <= StClrRow;
                    end else begin
                        vram_we_q <= 1'b0;
                        ack_q     <= 1'b1;
                        state_q   <= StAck;
                    end
                end

                StClrRow: begin
                    if (vram_addr_q[5:0] == 6'd63) begin
                        vram_we_q <= 1'b0;
                        ack_q     <= 1'b1;
                        state_q   <= StAck;
                    end else begin
                        vram_addr_q <= vram_addr_q + 10'd1;
                    end
                end

                StClrAll: begin
                    if (vram_addr_q == 10'd1023) begin
                        vram_we_q <= 1'b0;
                        col_q     <= 6'd0;
                        row_q     <= 4'd0;
                        ack_q     <= 1'b1;
                        state_q   <= StAck;
                    end else begin
                        vram_addr_q <= vram_addr_q + 10'd1;
                    end
                end

                StAck: begin
                    ack_q   <= 1'b0;
                    dat_o_q <= 32'h0;
                    state_q <= StIdle;
                end

                default: begin
                    vram_we_q <= 1'b0;
                    ack_q     <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign W_ACK     = ack_q;
    assign W_DAT_O   = dat_o_q;
    assign vram_we   = vram_we_q;
    assign vram_addr = vram_addr_q;
    assign vram_data = vram_data_q;

endmodule

// File: tb/tb_gpu_text_writer.sv
// Directed bench for gpu_text_writer: register access, character handling,
// row wrap, line feed, screen clear, reset abort and held-strobe behaviour.

module tb_gpu_text_writer;

    logic        clk = 1'b0;
    logic        W_RST;
    logic        W_STB;
    logic        W_WE;
    logic [31:0] W_ADDR;
    logic [31:0] W_DAT_I;
    logic [31:0] W_DAT_O;
    logic        W_ACK;
    logic [9:0]  vram_addr;
    logic [15:0] vram_data;
    logic        vram_we;

    int n_checks = 0;
    int n_errors = 0;

    // Captured VRAM writes of the current transaction.
    logic [9:0]  wa[$];
    logic [15:0] wd[$];
    int          wc[$];

    always #5 clk = ~clk;

    gpu_text_writer dut (
        .clk       (clk),
        .W_RST     (W_RST),
        .W_STB     (W_STB),
        .W_WE      (W_WE),
        .W_ADDR    (W_ADDR),
        .W_DAT_I   (W_DAT_I),
        .W_DAT_O   (W_DAT_O),
        .W_ACK     (W_ACK),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .vram_we   (vram_we)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus transaction; the master holds W_STB until W_ACK and scrambles the
    // bus after the accept cycle to show the request was registered.
    task automatic run_txn(input logic we, input logic [1:0] sel, input logic [31:0] dat,
                           input int maxc, output int ack_cyc, output logic [31:0] rdata);
        ack_cyc = -1;
        rdata   = 32'h0;
        wa.delete();
        wd.delete();
        wc.delete();
        W_WE    = we;
        W_ADDR  = {28'hA5C3_7E1, sel, 2'b01};
        W_DAT_I = dat;
        W_STB   = 1'b1;
        for (int c = 1; c <= maxc; c++) begin
            tick();
            if (c == 1) begin
                W_WE    = ~we;
                W_ADDR  = W_ADDR ^ 32'h0000_000C;
                W_DAT_I = ~dat;
            end
            if (vram_we) begin
                wa.push_back(vram_addr);
                wd.push_back(vram_data);
                wc.push_back(c);
            end
            if (W_ACK) begin
                ack_cyc = c;
                rdata   = W_DAT_O;
                check("we_low_in_ack", {31'h0, vram_we}, 32'h0);
                W_STB   = 1'b0;
                break;
            end
        end
        check("ack_seen", {31'h0, ack_cyc >= 0}, 32'h1);
        tick();
        check("ack_one_cycle", {31'h0, W_ACK}, 32'h0);
        check("we_low_idle", {31'h0, vram_we}, 32'h0);
    endtask

    task automatic reg_read(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        int          ac;
        logic [31:0] rd;
        run_txn(1'b0, sel, 32'h0, 4, ac, rd);
        check({tag, "_ack_cyc"}, ac, 1);
        check(tag, rd, exp);
    endtask

    task automatic reg_write(input string tag, input logic [1:0] sel, input logic [31:0] dat);
        int          ac;
        logic [31:0] rd;
        run_txn(1'b1, sel, dat, 4, ac, rd);
        check({tag, "_ack_cyc"}, ac, 1);
        check({tag, "_no_vram"}, wa.size(), 0);
    endtask

    // Check captured writes idx0.. idx0+n-1: ascending addresses from base, fixed data,
    // consecutive cycles from cyc0.
    task automatic check_seq(input string tag, input int idx0, input int n,
                             input logic [9:0] base, input logic [15:0] data, input int cyc0);
        for (int k = 0; k < n; k++) begin
            if (idx0 + k < wa.size()) begin
                check({tag, "_addr"}, {22'h0, wa[idx0+k]}, {22'h0, base + 10'(k)});
                check({tag, "_data"}, {16'h0, wd[idx0+k]}, {16'h0, data});
                check({tag, "_cyc"}, wc[idx0+k], cyc0 + k);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ac;
        logic [31:0] rd;
        int          nwe;
        int          nack;

        W_RST   = 1'b1;
        W_STB   = 1'b0;
        W_WE    = 1'b0;
        W_ADDR  = 32'h0;
        W_DAT_I = 32'h0;
        tick();
        tick();
        W_RST = 1'b0;
        check("rst_ack", {31'h0, W_ACK}, 32'h0);
        check("rst_dat_o", W_DAT_O, 32'h0);
        check("rst_we", {31'h0, vram_we}, 32'h0);
        check("rst_addr", {22'h0, vram_addr}, 32'h0);
        check("rst_data", {16'h0, vram_data}, 32'h0);
        reg_read("rst_cursor", 2'd1, 32'h0);
        reg_read("rst_attr", 2'd3, 32'h0);
        reg_read("rst_data_reg", 2'd0, 32'h0);

        // Printable character without wrap.
        reg_write("attr_wr", 2'd3, 32'h0000_001F);
        run_txn(1'b1, 2'd0, 32'h0000_0041, 8, ac, rd);
        check("chr_ack_cyc", ac, 2);
        check("chr_nwr", wa.size(), 1);
        check_seq("chr", 0, 1, 10'h000, 16'h1F41, 1);
        reg_read("chr_cursor", 2'd1, 32'h0000_0001);
        reg_read("chr_data_reg", 2'd0, 32'h0000_1F41);
        reg_read("attr_rd", 2'd3, 32'h0000_001F);

        // Printable at (15,63): wrap to row 0 and clear it.
        reg_write("cur_wr_f3f", 2'd1, 32'h0000_0F3F);
        reg_read("cur_rd_f3f", 2'd1, 32'h0000_0F3F);
        run_txn(1'b1, 2'd0, 32'h0000_0042, 80, ac, rd);
        check("wrap_ack_cyc", ac, 66);
        check("wrap_nwr", wa.size(), 65);
        check_seq("wrap_chr", 0, 1, 10'h3FF, 16'h1F42, 1);
        check_seq("wrap_clr", 1, 64, 10'h000, 16'h1F20, 2);
        reg_read("wrap_cursor", 2'd1, 32'h0000_0000);

        // Line feed from (3,10).
        reg_write("cur_wr_30a", 2'd1, 32'h0000_030A);
        run_txn(1'b1, 2'd0, 32'h0000_000A, 80, ac, rd);
        check("lf_ack_cyc", ac, 65);
        check("lf_nwr", wa.size(), 64);
        check_seq("lf_clr", 0, 64, 10'h100, 16'h1F20, 1);
        reg_read("lf_cursor", 2'd1, 32'h0000_0400);

        // CR and BS at col 0.
        reg_write("cr_col0", 2'd0, 32'h0000_000D);
        reg_read("cr_col0_cursor", 2'd1, 32'h0000_0400);
        reg_write("bs_col0", 2'd0, 32'h0000_0008);
        reg_read("bs_col0_cursor", 2'd1, 32'h0000_0400);
        // BS and CR at a nonzero column.
        reg_write("cur_wr_405", 2'd1, 32'h0000_0405);
        reg_write("bs_col5", 2'd0, 32'h0000_0008);
        reg_read("bs_col5_cursor", 2'd1, 32'h0000_0404);
        reg_write("cr_col4", 2'd0, 32'h0000_000D);
        reg_read("cr_col4_cursor", 2'd1, 32'h0000_0400);
        reg_read("data_after_ctl", 2'd0, 32'h0000_1F42);

        // CTRL read, CTRL no-op, screen clear.
        reg_read("ctrl_rd", 2'd2, 32'h0000_1040);
        reg_write("cur_wr_507", 2'd1, 32'h0000_0507);
        reg_write("ctrl_noop", 2'd2, 32'h0000_0000);
        reg_read("ctrl_noop_cursor", 2'd1, 32'h0000_0507);
        run_txn(1'b1, 2'd2, 32'h0000_0001, 1100, ac, rd);
        check("scr_ack_cyc", ac, 1025);
        check("scr_nwr", wa.size(), 1024);
        check_seq("scr", 0, 1024, 10'h000, 16'h1F20, 1);
        reg_read("scr_cursor", 2'd1, 32'h0000_0000);

        // Reset at cycle 500 of a screen clear.
        reg_write("cur_wr_abort", 2'd1, 32'h0000_0203);
        W_WE    = 1'b1;
        W_ADDR  = 32'h0000_0008;
        W_DAT_I = 32'h0000_0001;
        W_STB   = 1'b1;
        nwe     = 0;
        nack    = 0;
        for (int c = 1; c <= 500; c++) begin
            tick();
            if (vram_we) nwe++;
            if (W_ACK) nack++;
        end
        check("abort_nwr_before", nwe, 500);
        check("abort_addr_c500", {22'h0, vram_addr}, 32'd499);
        check("abort_nack_before", nack, 0);
        W_RST = 1'b1;
        W_STB = 1'b0;
        tick();
        check("abort_we", {31'h0, vram_we}, 32'h0);
        check("abort_ack", {31'h0, W_ACK}, 32'h0);
        check("abort_addr", {22'h0, vram_addr}, 32'h0);
        check("abort_data", {16'h0, vram_data}, 32'h0);
        check("abort_dat_o", W_DAT_O, 32'h0);
        W_RST = 1'b0;
        nwe   = 0;
        nack  = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (vram_we) nwe++;
            if (W_ACK) nack++;
        end
        check("abort_quiet_we", nwe, 0);
        check("abort_quiet_ack", nack, 0);
        reg_read("abort_attr", 2'd3, 32'h0);
        reg_read("abort_cursor", 2'd1, 32'h0);
        reg_read("abort_last", 2'd0, 32'h0);
        run_txn(1'b1, 2'd0, 32'h0000_0044, 8, ac, rd);
        check("post_chr_ack_cyc", ac, 2);
        check("post_chr_nwr", wa.size(), 1);
        check_seq("post_chr", 0, 1, 10'h000, 16'h0044, 1);

        // Strobe held through W_ACK: a second write starts right after the pulse.
        wa.delete();
        wd.delete();
        wc.delete();
        W_WE    = 1'b1;
        W_ADDR  = 32'h0000_0000;
        W_DAT_I = 32'h0000_0043;
        W_STB   = 1'b1;
        nack    = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (vram_we) begin
                wa.push_back(vram_addr);
                wd.push_back(vram_data);
                wc.push_back(c);
            end
            if (W_ACK) begin
                nack++;
                check("hold_ack_cyc", c, (nack == 1) ? 2 : 5);
            end
        end
        W_STB = 1'b0;
        check("hold_nack", nack, 2);
        check("hold_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            check("hold_w0_addr", {22'h0, wa[0]}, 32'h001);
            check("hold_w0_cyc", wc[0], 1);
            check("hold_w1_addr", {22'h0, wa[1]}, 32'h002);
            check("hold_w1_data", {16'h0, wd[1]}, 32'h0043);
            check("hold_w1_cyc", wc[1], 4);
        end
        nwe  = 0;
        nack = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (vram_we) nwe++;
            if (W_ACK) nack++;
        end
        check("drop_quiet_we", nwe, 0);
        check("drop_quiet_ack", nack, 0);
        reg_read("hold_cursor", 2'd1, 32'h0000_0003);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
